xm_stage: RTL
=============

Name: xm_stage

Overview:
- Execute-to-memory pipeline stage directly downstream of the 32-bit ALU.
- Registers the ALU result and flags along with the instruction's control fields.
- Resolves bne/blt/j/jal/jr/bex, issues a registered PC redirect, and substitutes $rstatus (r30) exception writes on add/addi/sub overflow.
- Squashes the wrong-path instruction that is in execute when a redirect fires.

Parameters:
- RSTATUS_REG, 30, register index written on exception and by setx
- LINK_REG, 31, register index written by jal

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on the rising edge where it is high
- stall  in  1  hold all state this cycle
- in_valid  in  5-bit-free 1  execute slot holds a real instruction
- in_opcode  in  5  instruction opcode
- in_aluop  in  5  ALU opcode field (R-type)
- in_rd  in  5  destination/compare register index
- in_pc  in  32  PC+1 of the instruction
- in_imm  in  32  sign-extended immediate
- in_target  in  27  J-type target
- in_rd_val  in  32  value of $rd (jr target, sw data)
- in_rstatus  in  32  forwarded current $rstatus value
- alu_result  in  32  ALU data_result
- alu_ne  in  1  ALU isNotEqual
- alu_lt  in  1  ALU isLessThan
- alu_ovf  in  1  ALU overflow
- out_valid  out  1  memory-stage slot valid
- out_result  out  32  value to write back or memory address
- out_rd  out  5  writeback register index
- out_we  out  1  register write enable
- out_mem_we  out  1  store (sw)
- out_mem_re  out  1  load (lw)
- out_store_data  out  32  sw data
- out_exc  out  1  exception substituted this slot
- redirect  out  1  fetch must jump; upstream flushes F/D
- redirect_pc  out  32  redirect target

Behaviour:
- Reset: every output and internal register is 0. This includes redirect, out_valid, and squash.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Stall high (and reset low): every register holds, including redirect, redirect_pc, and squash. Inputs are ignored.
- Squash rule: on a non-stalled edge where redirect is currently 1, the execute instruction is wrong-path.
  - It is captured as a bubble: out_valid=0, out_we=0, out_mem_we=0, out_mem_re=0, out_exc=0, redirect=0.
  - A branch cannot redirect twice back-to-back.
- Bubble capture: when in_valid=0, the stage captures a bubble with all enables 0.
- Opcodes:
  - R-type 00000, aluops: add 00000, sub 00001, and 00010, or 00011, sll 00100, srl 00101.
  - j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110.
  - Any other opcode or aluop is captured as a bubble.
- Result and writeback for valid, non-squashed instructions:
  - R-type and addi: out_result=alu_result, out_rd=in_rd, out_we=(in_rd!=0).
  - lw: out_result=alu_result, out_mem_re=1, out_rd=in_rd, out_we=(in_rd!=0).
  - sw: out_result=alu_result, out_mem_we=1, out_store_data=in_rd_val, out_we=0.
  - jal: out_result=in_pc, out_rd=LINK_REG, out_we=1.
  - setx: out_result={5'b0,in_target}, out_rd=RSTATUS_REG, out_we=1.
  - Branches, j, jr, bex: out_we=0.
- Overflow substitution: applies when alu_ovf=1 on add, addi, or sub.
  - out_rd=RSTATUS_REG, out_we=1, out_exc=1.
  - out_result is 1 for add, 2 for addi, 3 for sub.
  - alu_ovf is ignored for every other op.
- Redirect (registered, asserted for exactly one non-stalled cycle):
  - bne when alu_ne=1: redirect_pc=in_pc+in_imm, modulo 2^32, wrap allowed.
  - blt when alu_lt=1: redirect_pc=in_pc+in_imm.
  - j and jal: redirect_pc={5'b0,in_target}.
  - jr: redirect_pc=in_rd_val.
  - bex when in_rstatus!=0: redirect_pc={5'b0,in_target}.
  - Not-taken branch: redirect=0; redirect_pc holds its previous value.
- Reset mid-stall or mid-redirect: reset wins; outputs return to 0 on that edge.

Decomposition:
- Shared package holds:
  - opcode and aluop constants;
  - exception codes EXC_ADD=1, EXC_ADDI=2, EXC_SUB=3;
  - register index constants for r0, r30, r31.
- One combinational sub-module, branch_resolve: inputs are opcode, flags, in_pc, in_imm, in_target, in_rd_val and in_rstatus; outputs are taken and target.
- The pipeline registers and squash logic stay in xm_stage.

Test Plan:
- add, rd=5, alu_result=0x7, ovf=0 -> next cycle out_valid=1, out_rd=5, out_we=1, out_result=0x7, out_exc=0.
- sub, rd=5, ovf=1 -> out_rd=30, out_result=3, out_exc=1; addi with ovf -> out_result=2; and with ovf=1 -> no exception.
- bne, in_pc=0x10, in_imm=0xFFFFFFFC, alu_ne=1 -> redirect=1, redirect_pc=0xC. Next edge's instruction (addi rd=4) is captured with out_valid=0; redirect drops to 0.
- jal, in_pc=0x21, target=0x100 -> out_rd=31, out_result=0x21, redirect_pc=0x100. Then bex with in_rstatus=0 -> redirect=0.
- stall held 3 cycles while redirect=1 -> all outputs frozen. First unstalled edge squashes the execute instruction.
- reset asserted during stall with redirect=1 -> all outputs 0 next edge. addi with rd=0 -> out_we=0.

Source files
------------

// File: rtl/xm_stage_pkg.sv
// xm_stage_pkg: opcodes, exception codes, register indices and the stage output record
package xm_stage_pkg;
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] AOP_ADD = 5'b00000;
    localparam logic [4:0] AOP_SUB = 5'b00001;
    localparam logic [4:0] AOP_AND = 5'b00010;
    localparam logic [4:0] AOP_OR  = 5'b00011;
    localparam logic [4:0] AOP_SLL = 5'b00100;
    localparam logic [4:0] AOP_SRL = 5'b00101;

    localparam logic [31:0] EXC_ADD  = 32'd1;
    localparam logic [31:0] EXC_ADDI = 32'd2;
    localparam logic [31:0] EXC_SUB  = 32'd3;

    localparam logic [4:0] REG_R0      = 5'd0;
    localparam logic [4:0] REG_RSTATUS = 5'd30;
    localparam logic [4:0] REG_LINK    = 5'd31;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        mem_we;
        logic        mem_re;
        logic [31:0] store_data;
        logic        exc;
    } xm_out_t;
endpackage

// File: rtl/xm_stage_if.sv
// xm_stage_if: execute-side inputs and memory-side outputs of the X/M stage
interface xm_stage_if;
    logic        stall;
    logic        in_valid;
    logic [4:0]  in_opcode;
    logic [4:0]  in_aluop;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic [26:0] in_target;
    logic [31:0] in_rd_val;
    logic [31:0] in_rstatus;
    logic [31:0] alu_result;
    logic        alu_ne;
    logic        alu_lt;
    logic        alu_ovf;
    logic        out_valid;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_mem_we;
    logic        out_mem_re;
    logic [31:0] out_store_data;
    logic        out_exc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output stall, in_valid, in_opcode, in_aluop, in_rd, in_pc, in_imm, in_target,
               in_rd_val, in_rstatus, alu_result, alu_ne, alu_lt, alu_ovf,
        input  out_valid, out_result, out_rd, out_we, out_mem_we, out_mem_re,
               out_store_data, out_exc, redirect, redirect_pc
    );

    modport slave (
        input  stall, in_valid, in_opcode, in_aluop, in_rd, in_pc, in_imm, in_target,
               in_rd_val, in_rstatus, alu_result, alu_ne, alu_lt, alu_ovf,
        output out_valid, out_result, out_rd, out_we, out_mem_we, out_mem_re,
               out_store_data, out_exc, redirect, redirect_pc
    );
endinterface

// File: rtl/xm_stage_branch_resolve.sv
// branch_resolve: decides whether the execute instruction changes control flow and where to
module branch_resolve
    import xm_stage_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic        alu_ne,
    input  logic        alu_lt,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_imm,
    input  logic [26:0] in_target,
    input  logic [31:0] in_rd_val,
    input  logic [31:0] in_rstatus,
    output logic        taken,
    output logic [31:0] target
);
    // PC-relative branches use pc+imm, absolute jumps use the zero-extended target field
    always_comb begin
        taken  = 1'b0;
        target = in_pc + in_imm;
        case (opcode)
            OP_BNE: taken = alu_ne;
            OP_BLT: taken = alu_lt;
            OP_J, OP_JAL: begin
                taken  = 1'b1;
                target = {5'b0, in_target};
            end
            OP_JR: begin
                taken  = 1'b1;
                target = in_rd_val;
            end
            OP_BEX: begin
                taken  = |in_rstatus;
                target = {5'b0, in_target};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/xm_stage.sv
// xm_stage: execute-to-memory pipeline register with branch redirect and overflow exceptions
module xm_stage
    import xm_stage_pkg::*;
#(
    parameter logic [4:0] RSTATUS_REG = REG_RSTATUS,
    parameter logic [4:0] LINK_REG    = REG_LINK
) (
    input logic       clock,
    input logic       reset,
    xm_stage_if.slave bus
);
    xm_out_t     out_d, out_q;
    logic        redirect_d, redirect_q;
    logic [31:0] redirect_pc_d, redirect_pc_q;
    logic        taken;
    logic [31:0] br_target;
    logic        live;
    logic        alu_ok;
    logic        ovf_exc;

    branch_resolve u_br (
        .opcode     (bus.in_opcode),
        .alu_ne     (bus.alu_ne),
        .alu_lt     (bus.alu_lt),
        .in_pc      (bus.in_pc),
        .in_imm     (bus.in_imm),
        .in_target  (bus.in_target),
        .in_rd_val  (bus.in_rd_val),
        .in_rstatus (bus.in_rstatus),
        .taken      (taken),
        .target     (br_target)
    );

    // A redirect registered last cycle means the execute slot holds a wrong-path instruction
    assign live    = bus.in_valid && !redirect_q;
    assign alu_ok  = bus.in_aluop inside {AOP_ADD, AOP_SUB, AOP_AND, AOP_OR, AOP_SLL, AOP_SRL};
    assign ovf_exc = bus.alu_ovf && ((bus.in_opcode == OP_RTYPE &&
                     (bus.in_aluop == AOP_ADD || bus.in_aluop == AOP_SUB)) || bus.in_opcode == OP_ADDI);

    // Decode the execute instruction into its memory-stage record and redirect request
    always_comb begin
        out_d         = '0;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (live) begin
            case (bus.in_opcode)
                OP_RTYPE, OP_ADDI, OP_LW: begin
                    if (bus.in_opcode != OP_RTYPE || alu_ok) begin
                        out_d.valid  = 1'b1;
                        out_d.result = bus.alu_result;
                        out_d.rd     = bus.in_rd;
                        out_d.we     = bus.in_rd != REG_R0;
                        out_d.mem_re = bus.in_opcode == OP_LW;
                    end
                end
                OP_SW: begin
                    out_d.valid      = 1'b1;
                    out_d.result     = bus.alu_result;
                    out_d.mem_we     = 1'b1;
                    out_d.store_data = bus.in_rd_val;
                end
                OP_JAL: begin
                    out_d.valid  = 1'b1;
                    out_d.result = bus.in_pc;
                    out_d.rd     = LINK_REG;
                    out_d.we     = 1'b1;
                end
                OP_SETX: begin
                    out_d.valid  = 1'b1;
                    out_d.result = {5'b0, bus.in_target};
                    out_d.rd     = RSTATUS_REG;
                    out_d.we     = 1'b1;
                end
                OP_J, OP_BNE, OP_JR, OP_BLT, OP_BEX: out_d.valid = 1'b1;
                default: ;
            endcase
            if (ovf_exc) begin
                out_d.rd     = RSTATUS_REG;
                out_d.we     = 1'b1;
                out_d.exc    = 1'b1;
                out_d.result = bus.in_opcode == OP_ADDI ? EXC_ADDI :
                               bus.in_aluop == AOP_SUB ? EXC_SUB : EXC_ADD;
            end
            redirect_d    = taken;
            redirect_pc_d = taken ? br_target : redirect_pc_q;
        end
    end

    // Pipeline registers: reset clears, stall holds, otherwise capture
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q         <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else if (!bus.stall) begin
            out_q         <= out_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.out_valid      = out_q.valid;
    assign bus.out_result     = out_q.result;
    assign bus.out_rd         = out_q.rd;
    assign bus.out_we         = out_q.we;
    assign bus.out_mem_we     = out_q.mem_we;
    assign bus.out_mem_re     = out_q.mem_re;
    assign bus.out_store_data = out_q.store_data;
    assign bus.out_exc        = out_q.exc;
    assign bus.redirect       = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
endmodule
